// File: rtl/packet_detect_pkg.sv
// Shared types for the packet detector: controller states and error cause codes.
package packet_detect_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        DRAIN   = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_RUNT_HDR = 2'd0;
    localparam logic [1:0] ERR_BAD_TYPE = 2'd1;
    localparam logic [1:0] ERR_SHORT    = 2'd2;
    localparam logic [1:0] ERR_LONG     = 2'd3;

endpackage

// File: rtl/sat_up_counter.sv
// Up-counter that saturates at LIMIT; clear wins over increment, and
// clear together with increment loads 1 (first item counted in the clearing cycle).
module sat_up_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_reg < WIDTH'(LIMIT))) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/packet_detect_fsm.sv
// Ethernet frame detector: steers bytes to header/payload checkers, counts
// payload bytes and classifies each frame with one-cycle done/error pulses.
module packet_detect_fsm
    import packet_detect_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HDR_BYTES   = 14,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int CNT_W       = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              control,
    input  logic [DATA_W-1:0] data,
    input  logic              type_length_valid,
    input  logic              packet_size_valid,
    output logic              enable_header,
    output logic              enable_payload,
    output logic [CNT_W-1:0]  payload_count,
    output logic              packet_done,
    output logic              packet_error,
    output logic [1:0]        error_code
);

    localparam int HC_W = $clog2(HDR_BYTES);

    state_t           state_reg;
    state_t           state_next;
    logic [HC_W-1:0]  hdr_cnt;
    logic             hdr_clear;
    logic             hdr_inc;
    logic             pay_clear;
    logic             pay_inc;
    logic             done_next;
    logic             error_next;
    logic [1:0]       code_next;
    logic             packet_done_reg;
    logic             packet_error_reg;
    logic [1:0]       error_code_reg;
    logic [CNT_W:0]   pay_n;
    logic             hdr_last;

    sat_up_counter #(
        .WIDTH (HC_W),
        .LIMIT (HDR_BYTES - 1)
    ) u_hdr_cnt (
        .clock (clock),
        .reset (reset),
        .clear (hdr_clear),
        .inc   (hdr_inc),
        .count (hdr_cnt)
    );

    sat_up_counter #(
        .WIDTH (CNT_W),
        .LIMIT (MAX_PAYLOAD)
    ) u_payload_cnt (
        .clock (clock),
        .reset (reset),
        .clear (pay_clear),
        .inc   (pay_inc),
        .count (payload_count)
    );

    // Count including the byte on the bus this cycle; one extra bit so it never wraps.
    assign pay_n    = {1'b0, payload_count} + (CNT_W + 1)'(1);
    assign hdr_last = (hdr_cnt == HC_W'(HDR_BYTES - 1));

    always_comb begin
        state_next = state_reg;
        hdr_clear  = 1'b0;
        hdr_inc    = 1'b0;
        pay_clear  = 1'b0;
        pay_inc    = 1'b0;
        done_next  = 1'b0;
        error_next = 1'b0;
        code_next  = error_code_reg;
        case (state_reg)
            IDLE: begin
                if (control) begin
                    hdr_clear  = 1'b1;
                    hdr_inc    = 1'b1;
                    pay_clear  = 1'b1;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (!control) begin
                    state_next = ERROR;
                    error_next = 1'b1;
                    code_next  = ERR_RUNT_HDR;
                end else if (hdr_last) begin
                    if (type_length_valid) begin
                        state_next = PAYLOAD;
                    end else begin
                        state_next = ERROR;
                        error_next = 1'b1;
                        code_next  = ERR_BAD_TYPE;
                    end
                end else begin
                    hdr_inc = 1'b1;
                end
            end
            PAYLOAD: begin
                if (!control) begin
                    state_next = ERROR;
                    error_next = 1'b1;
                    code_next  = ERR_SHORT;
                end else begin
                    pay_inc = 1'b1;
                    if (packet_size_valid) begin
                        if (pay_n >= (CNT_W + 1)'(MIN_PAYLOAD)) begin
                            state_next = DRAIN;
                        end else begin
                            state_next = ERROR;
                            error_next = 1'b1;
                            code_next  = ERR_SHORT;
                        end
                    end else if (pay_n == (CNT_W + 1)'(MAX_PAYLOAD)) begin
                        state_next = ERROR;
                        error_next = 1'b1;
                        code_next  = ERR_LONG;
                    end
                end
            end
            DRAIN: begin
                if (!control && (data == '0)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            ERROR: begin
                if (!control) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            packet_done_reg  <= 1'b0;
            packet_error_reg <= 1'b0;
            error_code_reg   <= ERR_RUNT_HDR;
        end else begin
            state_reg        <= state_next;
            packet_done_reg  <= done_next;
            packet_error_reg <= error_next;
            error_code_reg   <= code_next;
        end
    end

    assign enable_header  = control && ((state_reg == IDLE) || (state_reg == HEADER));
    assign enable_payload = control && (state_reg == PAYLOAD);
    assign packet_done    = packet_done_reg;
    assign packet_error   = packet_error_reg;
    assign error_code     = error_code_reg;

endmodule

// File: tb/tb_packet_detect_fsm.sv
// Frame-level bench for packet_detect_fsm: frames are described by kind and
// byte counts, expanded into per-cycle stimulus plus expected outputs.
module tb_packet_detect_fsm;

    localparam int HB   = 4;
    localparam int MINP = 3;
    localparam int MAXP = 6;
    localparam int CW   = 3;

    localparam int K_LEGAL      = 0;
    localparam int K_RUNT       = 1;
    localparam int K_BAD        = 2;
    localparam int K_SHORT_PSV  = 3;
    localparam int K_SHORT_DROP = 4;
    localparam int K_LONG       = 5;

    localparam int OP_NONE = 0;
    localparam int OP_CLR  = 1;
    localparam int OP_INC  = 2;

    logic          clock;
    logic          reset;
    logic          control;
    logic [7:0]    data;
    logic          type_length_valid;
    logic          packet_size_valid;
    logic          enable_header;
    logic          enable_payload;
    logic [CW-1:0] payload_count;
    logic          packet_done;
    logic          packet_error;
    logic [1:0]    error_code;

    packet_detect_fsm #(
        .DATA_W      (8),
        .HDR_BYTES   (HB),
        .MIN_PAYLOAD (MINP),
        .MAX_PAYLOAD (MAXP),
        .CNT_W       (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .control           (control),
        .data              (data),
        .type_length_valid (type_length_valid),
        .packet_size_valid (packet_size_valid),
        .enable_header     (enable_header),
        .enable_payload    (enable_payload),
        .payload_count     (payload_count),
        .packet_done       (packet_done),
        .packet_error      (packet_error),
        .error_code        (error_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          ctrl;
        logic [7:0]    data;
        logic          tlv;
        logic          psv;
        logic          eh;
        logic          ep;
        logic          done;
        logic          err;
        logic [CW-1:0] cnt;
        logic [1:0]    code;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    int   m_code = 0;
    bit   pend_done = 1'b0;
    bit   pend_err  = 1'b0;
    int   pend_code = 0;
    int   frame_no  = 0;

    // Append one cycle; events raised here become visible one cycle later.
    task automatic push(input logic c, input logic [7:0] d, input logic t, input logic p,
                        input logic eh, input logic ep, input bit ev_done, input int ev_err,
                        input int op);
        cyc_t x;
        if (pend_err) m_code = pend_code;
        x.ctrl = c;  x.data = d;  x.tlv = t;  x.psv = p;
        x.eh   = eh; x.ep   = ep;
        x.done = pend_done;
        x.err  = pend_err;
        x.cnt  = CW'(m_cnt);
        x.code = 2'(m_code);
        q.push_back(x);
        if (op == OP_CLR) m_cnt = 0;
        else if (op == OP_INC) m_cnt = m_cnt + 1;
        pend_done = ev_done;
        pend_err  = (ev_err >= 0);
        pend_code = ev_err;
    endtask

    task automatic add_frame(input int kind, input int n, input int extra, input int stall,
                             input int gap);
        int hlen;
        hlen = (kind == K_RUNT) ? n : HB;
        $display("frame %0d: kind=%0d n=%0d extra=%0d stall=%0d gap=%0d",
                 frame_no, kind, n, extra, stall, gap);
        frame_no++;
        for (int k = 0; k < hlen; k++) begin
            push(1'b1, 8'($urandom_range(1, 255)),
                 (k == HB - 1) ? logic'(kind != K_BAD) : 1'($urandom), 1'($urandom),
                 1'b1, 1'b0, 1'b0, (k == HB - 1 && kind == K_BAD) ? 1 : -1,
                 (k == 0) ? OP_CLR : OP_NONE);
        end
        if (kind == K_RUNT) begin
            push(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 0, OP_NONE);
        end else if (kind != K_BAD) begin
            for (int k = 1; k <= n; k++) begin
                push(1'b1, 8'($urandom), 1'($urandom),
                     (k == n) && (kind == K_LEGAL || kind == K_SHORT_PSV),
                     1'b0, 1'b1, 1'b0,
                     (k == n && kind == K_SHORT_PSV) ? 2 : (k == n && kind == K_LONG) ? 3 : -1,
                     OP_INC);
            end
            if (kind == K_SHORT_DROP)
                push(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 2, OP_NONE);
        end
        if (kind == K_LEGAL) begin
            for (int k = 0; k < extra; k++)
                push(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, -1, OP_NONE);
            for (int k = 0; k < stall; k++)
                push(1'b0, 8'($urandom_range(1, 255)), 1'($urandom), 1'($urandom),
                     1'b0, 1'b0, 1'b0, -1, OP_NONE);
            push(1'b0, 8'h00, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, -1, OP_NONE);
        end else if (kind == K_BAD || kind == K_SHORT_PSV || kind == K_LONG) begin
            for (int k = 0; k < extra; k++)
                push(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, -1, OP_NONE);
        end
        for (int k = 0; k < gap; k++)
            push(1'b0, 8'h00, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, -1, OP_NONE);
    endtask

    // Drive the queued cycles and compare every output mid-cycle.
    task automatic play();
        foreach (q[i]) begin
            @(posedge clock);
            #1;
            control           = q[i].ctrl;
            data              = q[i].data;
            type_length_valid = q[i].tlv;
            packet_size_valid = q[i].psv;
            @(negedge clock);
            checks += 6;
            if (enable_header !== q[i].eh) begin
                errors++;
                $display("FAIL enable_header cycle %0d: got %b expected %b", i, enable_header, q[i].eh);
            end
            if (enable_payload !== q[i].ep) begin
                errors++;
                $display("FAIL enable_payload cycle %0d: got %b expected %b", i, enable_payload, q[i].ep);
            end
            if (packet_done !== q[i].done) begin
                errors++;
                $display("FAIL packet_done cycle %0d: got %b expected %b", i, packet_done, q[i].done);
            end
            if (packet_error !== q[i].err) begin
                errors++;
                $display("FAIL packet_error cycle %0d: got %b expected %b", i, packet_error, q[i].err);
            end
            if (error_code !== q[i].code) begin
                errors++;
                $display("FAIL error_code cycle %0d: got %0d expected %0d", i, error_code, q[i].code);
            end
            if (payload_count !== q[i].cnt) begin
                errors++;
                $display("FAIL payload_count cycle %0d: got %0d expected %0d", i, payload_count, q[i].cnt);
            end
        end
        q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        control = 1'b0;
        data = 8'h00;
        type_length_valid = 1'b0;
        packet_size_valid = 1'b0;
        #7;
        checks += 4;
        if (payload_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", payload_count);
        end
        if (packet_done !== 1'b0 || packet_error !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got %b%b expected 00", packet_done, packet_error);
        end
        if (error_code !== 2'd0) begin
            errors++; $display("FAIL reset_code: got %0d expected 0", error_code);
        end
        if (enable_header !== 1'b0 || enable_payload !== 1'b0) begin
            errors++; $display("FAIL reset_enables: got %b%b expected 00", enable_header, enable_payload);
        end
        @(negedge clock);
        reset = 1'b0;
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, OP_NONE);
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, OP_NONE);
        play();
    endtask

    task automatic test_legal_frame();
        add_frame(K_LEGAL, 4, 2, 0, 2);
        play();
        checks++;
        if (payload_count !== 3'd4) begin
            errors++; $display("FAIL legal_final_count: got %0d expected 4", payload_count);
        end
    endtask

    task automatic test_errors();
        add_frame(K_RUNT, 2, 0, 0, 2);
        add_frame(K_BAD, 0, 3, 0, 1);
        add_frame(K_SHORT_PSV, 2, 1, 0, 1);
        add_frame(K_SHORT_DROP, 0, 0, 0, 1);
        add_frame(K_LONG, MAXP, 2, 0, 2);
        play();
    endtask

    task automatic test_async_reset();
        add_frame(K_LONG, MAXP, 0, 0, 1);
        for (int k = 0; k < HB; k++)
            push(1'b1, 8'($urandom_range(1, 255)), (k == HB - 1), 1'b0, 1'b1, 1'b0, 1'b0, -1,
                 (k == 0) ? OP_CLR : OP_NONE);
        push(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, OP_INC);
        push(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, OP_INC);
        play();
        #2;
        reset = 1'b1;
        #1;
        checks += 4;
        if (payload_count !== 3'd0) begin
            errors++; $display("FAIL async_reset_count: got %0d expected 0", payload_count);
        end
        if (error_code !== 2'd0) begin
            errors++; $display("FAIL async_reset_code: got %0d expected 0", error_code);
        end
        if (enable_payload !== 1'b0 || enable_header !== 1'b1) begin
            errors++; $display("FAIL async_reset_enables: got %b%b expected 10", enable_header, enable_payload);
        end
        if (packet_done !== 1'b0 || packet_error !== 1'b0) begin
            errors++; $display("FAIL async_reset_pulses: got %b%b expected 00", packet_done, packet_error);
        end
        control = 1'b0;
        data = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_cnt = 0;
        m_code = 0;
        pend_done = 1'b0;
        pend_err = 1'b0;
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, OP_NONE);
        add_frame(K_LEGAL, MINP, 1, 1, 2);
        play();
    endtask

    task automatic test_back_to_back();
        add_frame(K_LEGAL, 5, 1, 0, 0);
        add_frame(K_LEGAL, MAXP, 0, 1, 0);
        add_frame(K_SHORT_PSV, 1, 0, 0, 1);
        add_frame(K_LEGAL, MINP, 2, 0, 2);
        play();
    endtask

    task automatic test_random();
        int kind, n, extra, stall, gap;
        for (int f = 0; f < 60; f++) begin
            kind  = $urandom_range(0, 5);
            extra = $urandom_range(0, 2);
            stall = $urandom_range(0, 2);
            gap   = (kind == K_LEGAL) ? $urandom_range(0, 2) : $urandom_range(1, 3);
            case (kind)
                K_LEGAL:      n = $urandom_range(MINP, MAXP);
                K_RUNT:       n = $urandom_range(1, HB - 1);
                K_SHORT_PSV:  n = $urandom_range(1, MINP - 1);
                K_SHORT_DROP: n = $urandom_range(0, MAXP - 1);
                K_LONG:       n = MAXP;
                default:      n = 0;
            endcase
            add_frame(kind, n, extra, stall, gap);
        end
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, OP_NONE);
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, OP_NONE);
        play();
    endtask

    initial begin
        test_reset();
        test_legal_frame();
        test_errors();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_detect_fsm.md
Name: packet_detect_fsm

Overview:
- Parametrised next-generation Ethernet packet detector controller.
- Tracks header and payload byte positions with internal counters.
- Steers bytes to the header and payload modules via enable_header/enable_payload.
- Classifies each frame as complete or erroneous (runt header, bad type, short, long) and reports it with single-cycle status pulses.

Parameters:
- DATA_W, 8: data bus width, one byte-lane per cycle.
- HDR_BYTES, 14: header length in bytes; must be ≥ 2.
- MIN_PAYLOAD, 46: minimum legal payload byte count; must be ≥ 1.
- MAX_PAYLOAD, 1500: maximum legal payload byte count; must be > MIN_PAYLOAD.
- CNT_W, 11: payload counter width; must satisfy 2^CNT_W > MAX_PAYLOAD.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- control  in  1  frame-active; a byte is accepted in every cycle this is high.
- data  in  DATA_W  frame byte; all-zero while control is low marks the idle gap.
- type_length_valid  in  1  header checker: type/length field good; sampled on the last header byte.
- packet_size_valid  in  1  payload checker: declared size reached on this byte.
- enable_header  out  1  current byte belongs to the header.
- enable_payload  out  1  current byte belongs to the payload.
- payload_count  out  CNT_W  payload bytes accepted in the current or last frame.
- packet_done  out  1  one-cycle pulse: frame completed legally.
- packet_error  out  1  one-cycle pulse: frame aborted.
- error_code  out  2  cause of the error: 0 RUNT_HDR, 1 BAD_TYPE, 2 SHORT, 3 LONG; held until the next error.

Behaviour:
- Reset (asynchronous, dominates all other inputs):
  - state = IDLE; hdr_cnt = 0; payload_count = 0; packet_done = 0; packet_error = 0; error_code = 0.
- Enables (combinational, zero latency):
  - enable_header = control and state ∈ {IDLE, HEADER}.
  - enable_payload = control and state == PAYLOAD.
  - Both are 0 in DRAIN and ERROR.
- "Accepted byte" means control = 1 in that cycle.
- IDLE:
  - control = 1: this byte is header byte 0; hdr_cnt ← 1; payload_count ← 0; go to HEADER.
  - control = 0: stay in IDLE.
- HEADER (the byte index equals hdr_cnt):
  - control = 0 → ERROR, code RUNT_HDR.
  - Accepted byte with index < HDR_BYTES−1: hdr_cnt increments.
  - Accepted byte with index == HDR_BYTES−1 and type_length_valid = 1 → PAYLOAD.
  - Accepted byte with index == HDR_BYTES−1 and type_length_valid = 0 → ERROR, code BAD_TYPE.
- PAYLOAD (each accepted byte increments payload_count; n denotes the new count):
  - control = 0 → ERROR, code SHORT.
  - packet_size_valid = 1 and n ≥ MIN_PAYLOAD → DRAIN.
  - packet_size_valid = 1 and n < MIN_PAYLOAD → ERROR, code SHORT.
  - packet_size_valid = 0 and n == MAX_PAYLOAD → ERROR, code LONG.
  - payload_count never exceeds MAX_PAYLOAD.
- DRAIN (trailer/FCS bytes; not counted):
  - control = 0 and data == 0 → IDLE, with packet_done pulsed.
  - control = 0 and data ≠ 0: stay in DRAIN.
- ERROR:
  - Stay while control = 1.
  - control = 0 → IDLE; no packet_done pulse.
- Pulse timing:
  - packet_done and packet_error are registered.
  - Each is high for exactly one cycle, the first cycle in the destination state (IDLE and ERROR respectively).
  - error_code updates in that same cycle.
- Back-to-back frames: a byte accepted in the first IDLE cycle after DRAIN starts a new frame in that cycle, and packet_done is still pulsed.
- payload_count holds its final value through IDLE and is cleared only when a new frame starts.
- Illegal state encoding → IDLE on the next clock.

Decomposition:
- Package packet_detect_pkg holds:
  - the state enum (IDLE, HEADER, PAYLOAD, DRAIN, ERROR);
  - the error_code localparams (ERR_RUNT_HDR, ERR_BAD_TYPE, ERR_SHORT, ERR_LONG).
- One sub-module, sat_up_counter (parametrised width and limit, with clear and increment), instantiated twice: hdr_cnt and payload_count.

Test Plan (HDR_BYTES=4, MIN_PAYLOAD=3, MAX_PAYLOAD=6, CNT_W=3):
- Legal frame:
  - Stimulus: 4 header bytes with tlv on byte 3; 4 payload bytes with psv on byte 4; 2 trailer bytes; then control=0, data=0.
  - Response: enable_header high for 4 cycles; enable_payload high for 4 cycles; packet_done pulses once; payload_count = 4; packet_error never asserts.
- Runt header:
  - Stimulus: control drops after 2 header bytes.
  - Response: next cycle packet_error = 1, error_code = 0; IDLE once control is low.
- Bad type:
  - Stimulus: 4 header bytes, tlv = 0.
  - Response: packet_error with code 1; enable_payload stays 0 for the remaining bytes of the frame.
- Short / long payload:
  - Stimulus: psv on payload byte 2.
  - Response: code 2, payload_count = 2.
  - Stimulus: 6 payload bytes, no psv.
  - Response: code 3, payload_count = 6.
- Async reset mid-payload:
  - Stimulus: assert reset between clock edges.
  - Response: outputs go to their reset values immediately; no done or error pulse; the next frame detects normally.
- Back-to-back frames:
  - Stimulus: a new header byte in the first IDLE cycle after DRAIN.
  - Response: packet_done pulses; the new frame is accepted with payload_count cleared to 0.
